ext_domain_pwr_seq: RTL and testbench

- Power-gate sequencer for one external power domain. It is the initiating end of the switch-cell handshake: it drives the switch enable, isolation, domain reset and clock-gate signals, and waits for the switch-cell acknowledge.
- Sits between the power-manager register interface (one-cycle on/off commands) and the external subsystem's switch cells.
- One instance per external domain.

---
 rtl/ext_domain_pwr_seq.sv | 166 ++++++++++++++++
 tb/tb_ext_domain_pwr_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_domain_pwr_seq.sv
// Power-gate sequencer for one external domain: drives switch, isolation, domain reset and
// clock gate in order, and waits on the synchronized switch acknowledge with an optional timeout.
module ext_domain_pwr_seq #(
  parameter int ISO_DELAY   = 4,
  parameter int RST_DELAY   = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwr_off_req_i,
  input  logic       pwr_on_req_i,
  input  logic       switch_ack_ni,
  output logic       switch_n_o,
  output logic       iso_n_o,
  output logic       rst_n_o,
  output logic       clkgate_en_n_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_ON       = 4'd0,
    ST_OFF      = 4'd1,
    ST_BOOT_RST = 4'd2,
    ST_CG       = 4'd3,
    ST_ISO      = 4'd4,
    ST_RST      = 4'd5,
    ST_SW_OFF   = 4'd6,
    ST_SW_ON    = 4'd7,
    ST_WAIT_RST = 4'd8,
    ST_ISO_REL  = 4'd9,
    ST_CG_REL   = 4'd10,
    ST_ERR      = 4'd15
  } state_t;

  // Delays are compared against N-1 so a delay of N occupies its state for exactly N cycles.
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic             TMO_EN   = (ACK_TIMEOUT != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ack_sync;
  logic             ack_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ack_sync <= 2'b00;
    else       ack_sync <= {ack_sync[0], switch_ack_ni};
  end

  assign ack_s   = ack_sync[1];
  assign state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_BOOT_RST;
      cnt            <= '0;
      switch_n_o     <= 1'b0;
      iso_n_o        <= 1'b1;
      rst_n_o        <= 1'b0;
      clkgate_en_n_o <= 1'b1;
      busy_o         <= 1'b1;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      cnt    <= cnt + CNT_W'(1);
      case (state)
        ST_BOOT_RST: if (cnt == RST_LAST) begin
          state   <= ST_ON;
          cnt     <= '0;
          rst_n_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        ST_ON: begin
          cnt <= '0;
          if (pwr_off_req_i && !pwr_on_req_i) begin
            state          <= ST_CG;
            clkgate_en_n_o <= 1'b0;
            busy_o         <= 1'b1;
          end
        end
        ST_CG: begin
          state   <= ST_ISO;
          cnt     <= '0;
          iso_n_o <= 1'b0;
        end
        ST_ISO: if (cnt == ISO_LAST) begin
          state   <= ST_RST;
          cnt     <= '0;
          rst_n_o <= 1'b0;
        end
        ST_RST: begin
          state      <= ST_SW_OFF;
          cnt        <= '0;
          switch_n_o <= 1'b1;
        end
        ST_SW_OFF: begin
          if (ack_s) begin
            state  <= ST_OFF;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (TMO_EN && cnt == TMO_LAST) begin
            state   <= ST_ERR;
            cnt     <= '0;
            busy_o  <= 1'b0;
            error_o <= 1'b1;
          end
        end
        ST_OFF: begin
          cnt <= '0;
          if (pwr_on_req_i && !pwr_off_req_i) begin
            state      <= ST_SW_ON;
            switch_n_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        ST_SW_ON: begin
          if (!ack_s) begin
            state <= ST_WAIT_RST;
            cnt   <= '0;
          end else if (TMO_EN && cnt == TMO_LAST) begin
            state   <= ST_ERR;
            cnt     <= '0;
            busy_o  <= 1'b0;
            error_o <= 1'b1;
          end
        end
        ST_WAIT_RST: if (cnt == RST_LAST) begin
          state   <= ST_ISO_REL;
          cnt     <= '0;
          rst_n_o <= 1'b1;
        end
        ST_ISO_REL: if (cnt == ISO_LAST) begin
          state   <= ST_CG_REL;
          cnt     <= '0;
          iso_n_o <= 1'b1;
        end
        ST_CG_REL: begin
          state          <= ST_ON;
          cnt            <= '0;
          clkgate_en_n_o <= 1'b1;
          busy_o         <= 1'b0;
          done_o         <= 1'b1;
        end
        // ERR freezes the domain-facing outputs; only rst_i leaves it.
        ST_ERR: cnt <= '0;
        default: begin
          state   <= ST_ERR;
          cnt     <= '0;
          busy_o  <= 1'b0;
          error_o <= 1'b1;
        end
      endcase
    end
  end

  // A switched-off domain must always be isolated and held in reset.
  assert property (@(posedge clk_i) disable iff (rst_i) switch_n_o |-> (!iso_n_o && !rst_n_o));

endmodule

// File: tb/tb_ext_domain_pwr_seq.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle stamps,
// a monitor pops one entry per observed change and compares.
module tb_ext_domain_pwr_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       pwr_off_req_i = 1'b0;
  logic       pwr_on_req_i = 1'b0;
  logic       switch_ack_ni;
  logic       switch_n_o, iso_n_o, rst_n_o, clkgate_en_n_o, busy_o, done_o, error_o;
  logic [3:0] state_o;

  ext_domain_pwr_seq #(
    .ISO_DELAY(4), .RST_DELAY(8), .ACK_TIMEOUT(64), .CNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pwr_off_req_i(pwr_off_req_i), .pwr_on_req_i(pwr_on_req_i),
    .switch_ack_ni(switch_ack_ni),
    .switch_n_o(switch_n_o), .iso_n_o(iso_n_o), .rst_n_o(rst_n_o),
    .clkgate_en_n_o(clkgate_en_n_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Switch-cell model: acknowledge echoes switch_n after 15 cycles, or stays low when stuck.
  logic [14:0] pipe = '0;
  bit stuck = 1'b0;
  always @(posedge clk_i) pipe <= {pipe[13:0], switch_n_o};
  assign switch_ack_ni = stuck ? 1'b0 : pipe[14];

  typedef struct packed {
    logic [3:0] st;
    logic sw, iso, rn, cg, busy, dn, er;
  } obs_t;

  typedef struct {
    string name;
    int    cyc;
    bit    tchk;
    obs_t  o;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic obs_t mk(input logic [3:0] s, input logic sw, input logic iso,
                              input logic rn, input logic cg, input logic busy,
                              input logic dn, input logic er);
    return {s, sw, iso, rn, cg, busy, dn, er};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d sw=%b iso=%b rst=%b cg=%b busy=%b done=%b err=%b",
                     o.st, o.sw, o.iso, o.rn, o.cg, o.busy, o.dn, o.er);
  endfunction

  task automatic push(input string nm, input int c, input bit tc, input obs_t o);
    exp_t e;
    e.name = nm; e.cyc = c; e.tchk = tc; e.o = o;
    exp_q.push_back(e);
  endtask

  // Power-down from ON requested at cycle r: CG, ISO, RST, SW_OFF entries.
  task automatic expect_down_front(input int r);
    push("cg",     r + 1, 1'b1, mk(4'd3, 0, 1, 1, 0, 1, 0, 0));
    push("iso",    r + 2, 1'b1, mk(4'd4, 0, 0, 1, 0, 1, 0, 0));
    push("rst",    r + 6, 1'b1, mk(4'd5, 0, 0, 0, 0, 1, 0, 0));
    push("sw_off", r + 7, 1'b1, mk(4'd6, 1, 0, 0, 0, 1, 0, 0));
  endtask

  // SW_OFF at r+7, ack_n rises 15 cycles later, 2-flop sync, seen on edge r+25.
  task automatic expect_off(input int r);
    push("off_done", r + 25, 1'b1, mk(4'd1, 1, 0, 0, 0, 0, 1, 0));
    push("off_idle", r + 26, 1'b1, mk(4'd1, 1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic expect_up(input int r);
    push("sw_on",    r + 1,  1'b1, mk(4'd7,  0, 0, 0, 0, 1, 0, 0));
    push("wait_rst", r + 19, 1'b1, mk(4'd8,  0, 0, 0, 0, 1, 0, 0));
    push("iso_rel",  r + 27, 1'b1, mk(4'd9,  0, 0, 1, 0, 1, 0, 0));
    push("cg_rel",   r + 31, 1'b1, mk(4'd10, 0, 1, 1, 0, 1, 0, 0));
    push("on_done",  r + 32, 1'b1, mk(4'd0,  0, 1, 1, 1, 0, 1, 0));
    push("on_idle",  r + 33, 1'b1, mk(4'd0,  0, 1, 1, 1, 0, 0, 0));
  endtask

  // Called at a negedge; drives a one-cycle request and returns at the next negedge.
  task automatic req(input bit off, input bit on);
    pwr_off_req_i = off;
    pwr_on_req_i  = on;
    @(negedge clk_i);
    pwr_off_req_i = 1'b0;
    pwr_on_req_i  = 1'b0;
  endtask

  // Asserts rst_i mid-way through the high clock phase so an async reset shows before the next edge.
  task automatic assert_rst(input string nm);
    @(posedge clk_i);
    #2;
    push(nm, cyc, 1'b1, mk(4'd2, 0, 1, 0, 1, 1, 0, 0));
    rst_i = 1'b1;
  endtask

  task automatic release_rst();
    @(negedge clk_i);
    push("boot_on", cyc + 8, 1'b1, mk(4'd0, 0, 1, 1, 1, 0, 0, 0));
    rst_i = 1'b0;
  endtask

  // Monitor: every change of the observed outputs consumes one expected entry.
  initial begin
    obs_t cur, prev;
    exp_t e;
    bit first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk_i or posedge rst_i);
      #1;
      cur = {state_o, switch_n_o, iso_n_o, rst_n_o, clkgate_en_n_o, busy_o, done_o, error_o};
      if (first || cur !== prev) begin
        first = 1'b0;
        prev  = cur;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got cyc=%0d %s, want no change", cyc, fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || (e.tchk && cyc != e.cyc)) begin
            errors++;
            $display("FAIL %s: got cyc=%0d %s, want cyc=%0d %s", e.name, cyc, fmt(cur), e.cyc, fmt(e.o));
          end
        end
      end
    end
  end

  initial begin
    int r;
    #1;
    push("reset", 0, 1'b0, mk(4'd2, 0, 1, 0, 1, 1, 0, 0));
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    release_rst();
    repeat (30) @(negedge clk_i);

    // Ignored requests in ON.
    req(1'b1, 1'b1);
    repeat (3) @(negedge clk_i);
    req(1'b0, 1'b1);
    repeat (3) @(negedge clk_i);

    // Power-down with stray requests during ISO.
    r = cyc;
    expect_down_front(r);
    expect_off(r);
    req(1'b1, 1'b0);
    repeat (2) @(negedge clk_i);
    req(1'b1, 1'b0);
    req(1'b0, 1'b1);
    repeat (40) @(negedge clk_i);

    // Ignored requests in OFF.
    req(1'b1, 1'b0);
    repeat (2) @(negedge clk_i);
    req(1'b1, 1'b1);
    repeat (20) @(negedge clk_i);

    // Power-up.
    r = cyc;
    expect_up(r);
    req(1'b0, 1'b1);
    repeat (45) @(negedge clk_i);

    // Acknowledge never arrives: timeout 64 cycles into SW_OFF.
    stuck = 1'b1;
    r = cyc;
    expect_down_front(r);
    push("err", r + 71, 1'b1, mk(4'd15, 1, 0, 0, 0, 0, 0, 1));
    req(1'b1, 1'b0);
    repeat (80) @(negedge clk_i);
    req(1'b0, 1'b1);
    repeat (5) @(negedge clk_i);
    assert_rst("reset_from_err");
    repeat (3) @(negedge clk_i);
    stuck = 1'b0;
    release_rst();
    repeat (40) @(negedge clk_i);

    // Reset asserted while waiting in SW_OFF.
    r = cyc;
    expect_down_front(r);
    req(1'b1, 1'b0);
    repeat (10) @(negedge clk_i);
    assert_rst("reset_in_sw_off");
    repeat (3) @(negedge clk_i);
    release_rst();
    repeat (30) @(negedge clk_i);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, want 0 (next %s)", exp_q.size(), exp_q[0].name);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
